tc_spi_responder: RTL and testbench
===================================

// Module: tc_spi_responder
//
// PURPOSE
// SPI responder (slave), SPI mode 1 (CPOL=0, CPHA=1): the device end of the GX_TC_SPI_* / GX_RTD_SPI_* buses.
// Used as the fabric-side ADC model in system benches, and in loopback self-test builds facing the PS SPI masters.
// Samples SCLK/CSN/MOSI with the system clock. Returns one DATA_WIDTH word per CSN frame from a one-entry TX holding register.
// Hands each received command word to the fabric as a one-cycle rx_valid strobe.
//
// PARAMETERS
// DATA_WIDTH   16  bits per frame (MSB first, both directions)
// SYNC_STAGES  2   flops in each SCLK/CSN/MOSI synchroniser (>=2)
//
// PORTS
// clk          in   1    system clock; all logic on rising edge
// rst_n        in   1    asynchronous active-low reset
// spi_csn      in   1    chip select, active low
// spi_sclk     in   1    SPI clock, idles low
// spi_mosi     in   1    master-out data (SDI)
// spi_miso     out  1    slave-out data (SDO)
// spi_miso_t   out  1    tristate enable for SDO, 1 = hi-Z
// tx_data      in   DW   next word to return to the master
// tx_valid     in   1    tx_data valid
// tx_ready     out  1    TX holding register empty
// rx_data      out  DW   last complete word received
// rx_valid     out  1    1-cycle strobe, rx_data updated
// tx_underrun  out  1    1-cycle strobe: frame started with TX holding register empty
// frame_err    out  1    1-cycle strobe: frame ended with bit count != DW
//
// BEHAVIOUR
// Reset values:
// - spi_miso=0, spi_miso_t=1, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0.
// - Holding register empty; state WAIT_HI.
// - Synchroniser resets: CSN chain to 0, SCLK chain to 0, MOSI chain to 0.
// Edge detection:
// - csn_fall, csn_rise, sclk_rise and sclk_fall are derived from the last two synchronised samples.
// - Each edge is a 1-cycle pulse.
// Timing limit:
// - SCLK high and low times must each be >= SYNC_STAGES+2 clk periods; default gives f_sclk <= f_clk/8.
// - CSN setup/hold to SCLK must be >= 1 SCLK half period.
// TX holding register:
// - A word is accepted on tx_valid && tx_ready; tx_ready drops the next cycle.
// - The register empties only when a frame loads it.
// - tx_valid while full is ignored; the word is not accepted.
// FSM:
// - WAIT_HI: ignore all edges. Go to IDLE when the synchronised CSN reads 1. This guarantees a frame cut by reset mid-frame is discarded.
// - IDLE: on csn_fall, load tx_shreg from the holding register and mark it empty. If the register is empty, load zeros and pulse tx_underrun. Then clear bit_cnt and rx_shreg, set spi_miso=0, and go to SHIFT.
//   - If tx_valid is accepted in the same cycle as csn_fall with the register empty, that word is NOT used for this frame: underrun pulses and the word stays held for the next frame.
// - SHIFT:
//   - sclk_rise: spi_miso <= tx_shreg[DW-1]; tx_shreg <= {tx_shreg[DW-2:0],1'b0}. The MSB therefore appears on the first rising edge. Bits past DW drive 0.
//   - sclk_fall: rx_shreg <= {rx_shreg[DW-2:0], mosi_s}; bit_cnt++ (saturating, width clog2(DW)+2).
//   - csn_rise with bit_cnt==DW: rx_data <= rx_shreg, rx_valid=1 for one cycle.
//   - csn_rise with any other bit_cnt (short, long or zero-length frame): frame_err=1 for one cycle; rx_data unchanged.
//   - Either way, go to IDLE.
//   - csn_rise and an SCLK edge in the same cycle: the CSN edge wins and the SCLK edge is dropped.
// spi_miso_t:
// - spi_miso_t = spi_csn (raw, combinational) OR (state != SHIFT), so SDO is released immediately on deselect.
// - spi_miso is forced to 0 whenever state != SHIFT.
// SCLK edges while CSN is high are ignored; no counter or register changes.
// Reset mid-frame: everything returns to reset values; the holding-register content is lost.
//
// TESTING
// 1. Load tx 0xA5C3. Master sends 0x8B0E, 16 clocks at f_clk/8 -> master reads 0xA5C3; rx_data=0x8B0E, rx_valid high 1 cycle after synchronised CSN rise; tx_ready back to 1 after CSN fall.
// 2. Holding register empty, full 16-bit frame -> tx_underrun 1 cycle at CSN fall; master reads 0x0000; rx_valid still asserted.
// 3. Master sends 12 clocks of 0xABC then 20 clocks -> frame_err pulses for each frame; no rx_valid; rx_data keeps its previous value.
// 4. rst_n pulsed low at bit 7 of a frame, released with CSN still low -> no rx_valid or frame_err for the rest of that frame; the next full frame returns correct data.
// 5. tx_valid(0x1234) in the same cycle as csn_fall with the register empty -> underrun, master reads 0x0000. A second tx_valid(0x5678) while full is not accepted. The next frame returns 0x1234.
// 6. 40 SCLK toggles with CSN high -> spi_miso_t=1, no strobes, state stays IDLE.

Source files
------------

// File: rtl/tc_spi_responder_if.sv
// SPI wires plus the fabric-side TX/RX handshake for tc_spi_responder.
// The slave modport is the responder's view; master is the SPI host / fabric view.
interface tc_spi_responder_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  spi_csn;
   logic                  spi_sclk;
   logic                  spi_mosi;
   logic                  spi_miso;
   logic                  spi_miso_t;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  tx_underrun;
   logic                  frame_err;

   modport slave (
      input  spi_csn, spi_sclk, spi_mosi, tx_data, tx_valid,
      output spi_miso, spi_miso_t, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
   );

   modport master (
      output spi_csn, spi_sclk, spi_mosi, tx_data, tx_valid,
      input  spi_miso, spi_miso_t, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
   );
endinterface

// File: rtl/tc_spi_responder.sv
// SPI mode-1 responder: oversamples SCLK/CSN/MOSI on clk, returns one word per
// CSN frame from a one-entry TX holding register and strobes each received word.
module tc_spi_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   tc_spi_responder_if.slave  bus
);
   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW) + 2;

   typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
   logic                   csn_prev_q, sclk_prev_q;
   logic                   csn_s, sclk_s, mosi_s;
   logic                   csn_fall, csn_rise, sclk_rise, sclk_fall;

   state_t                 state_q;
   logic [DW-1:0]          hold_q;
   logic                   full_q;
   logic [DW-1:0]          tx_shreg_q;
   logic [DW-1:0]          rx_shreg_q;
   logic [CW-1:0]          bit_cnt_q;
   logic                   miso_q;
   logic [DW-1:0]          rx_data_q;
   logic                   rx_valid_q;
   logic                   underrun_q;
   logic                   ferr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csn_sync_q  <= '0;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         csn_prev_q  <= 1'b0;
         sclk_prev_q <= 1'b0;
      end else begin
         csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  bus.spi_csn};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
         csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign csn_s     = csn_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign csn_fall  = csn_prev_q & ~csn_s;
   assign csn_rise  = ~csn_prev_q & csn_s;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_HI;
         hold_q     <= '0;
         full_q     <= 1'b0;
         tx_shreg_q <= '0;
         rx_shreg_q <= '0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         ferr_q     <= 1'b0;

         // Accept only when empty, so it can never collide with the frame load below,
         // and a word accepted in the csn_fall cycle is kept for the next frame.
         if (bus.tx_valid && !full_q) begin
            hold_q <= bus.tx_data;
            full_q <= 1'b1;
         end

         case (state_q)
            WAIT_HI: begin
               miso_q <= 1'b0;
               if (csn_s) state_q <= IDLE;
            end
            IDLE: begin
               miso_q <= 1'b0;
               if (csn_fall) begin
                  if (full_q) begin
                     tx_shreg_q <= hold_q;
                     full_q     <= 1'b0;
                  end else begin
                     tx_shreg_q <= '0;
                     underrun_q <= 1'b1;
                  end
                  bit_cnt_q  <= '0;
                  rx_shreg_q <= '0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               if (csn_rise) begin
                  if (bit_cnt_q == CW'(DW)) begin
                     rx_data_q  <= rx_shreg_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     ferr_q <= 1'b1;
                  end
                  miso_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  miso_q     <= tx_shreg_q[DW-1];
                  tx_shreg_q <= {tx_shreg_q[DW-2:0], 1'b0};
               end else if (sclk_fall) begin
                  rx_shreg_q <= {rx_shreg_q[DW-2:0], mosi_s};
                  if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + CW'(1);
               end
            end
            default: state_q <= WAIT_HI;
         endcase
      end
   end

   assign bus.spi_miso    = miso_q;
   assign bus.spi_miso_t  = bus.spi_csn | (state_q != SHIFT);
   assign bus.tx_ready    = ~full_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.frame_err   = ferr_q;
endmodule

// File: tb/tb_tc_spi_responder.sv
// Bench for tc_spi_responder: drives SPI mode-1 frames at f_clk/8 and scoreboards
// the strobes and the words read back on MISO.
module tb_tc_spi_responder;
   localparam int EV_NONE = 0;
   localparam int EV_UR   = 1;
   localparam int EV_RX   = 2;
   localparam int EV_FE   = 3;

   typedef struct {
      int          kind;
      logic [15:0] data;
   } ev_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   ev_t  evq[$];

   logic        model_full;
   logic [15:0] model_hold;
   logic [15:0] last_rx;

   tc_spi_responder_if #(.DATA_WIDTH(16)) bus ();

   tc_spi_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pop_cmp(input int kind, input logic [15:0] data);
      ev_t e;
      if (evq.size() != 0) e = evq.pop_front();
      else e = '{EV_NONE, 16'h0};
      check("evt_kind", 64'(kind), 64'(e.kind));
      if (kind == EV_RX && e.kind == EV_RX) check("rx_data_strobe", {48'h0, data}, {48'h0, e.data});
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tx_underrun) pop_cmp(EV_UR, 16'h0);
         if (bus.rx_valid)    pop_cmp(EV_RX, bus.rx_data);
         if (bus.frame_err)   pop_cmp(EV_FE, 16'h0);
      end
   end

   task automatic half_period();
      repeat (4) @(negedge clk);
   endtask

   task automatic load_tx(input logic [15:0] w);
      @(negedge clk);
      check("tx_ready_pre", {63'h0, bus.tx_ready}, {63'h0, ~model_full});
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (!model_full) begin
         model_full = 1'b1;
         model_hold = w;
      end
      check("tx_ready_post", {63'h0, bus.tx_ready}, {63'h0, ~model_full});
   endtask

   // rst_at >= 0 pulses reset before that bit; tx_fall presents tx_fall_word in the csn_fall cycle.
   task automatic frame(input logic [15:0] word, input int nbits, input int rst_at,
                        input bit tx_fall, input logic [15:0] tx_fall_word);
      logic [63:0] rd;
      logic [63:0] e;
      logic [63:0] expv;
      logic [15:0] expm;
      rd = '0;
      @(negedge clk);
      check("miso_t_idle", {63'h0, bus.spi_miso_t}, 64'h1);
      if (model_full) begin
         expm       = model_hold;
         model_full = 1'b0;
      end else begin
         expm = 16'h0;
         evq.push_back('{EV_UR, 16'h0});
      end
      bus.spi_csn = 1'b0;
      if (tx_fall) begin
         @(negedge clk);
         @(negedge clk);
         bus.tx_data  = tx_fall_word;
         bus.tx_valid = 1'b1;
         @(negedge clk);
         bus.tx_valid = 1'b0;
         model_full   = 1'b1;
         model_hold   = tx_fall_word;
         @(negedge clk);
      end else begin
         half_period();
      end
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n      = 1'b1;
            model_full = 1'b0;
            last_rx    = 16'h0;
         end
         bus.spi_mosi = (i < 16) ? word[15-i] : 1'b0;
         bus.spi_sclk = 1'b1;
         half_period();
         if (i == 1 && rst_at < 0) check("miso_t_active", {63'h0, bus.spi_miso_t}, 64'h0);
         rd = (rd << 1) | {63'h0, bus.spi_miso};
         bus.spi_sclk = 1'b0;
         half_period();
      end
      if (rst_at < 0) begin
         if (nbits == 16) begin
            evq.push_back('{EV_RX, word});
            last_rx = word;
         end else begin
            evq.push_back('{EV_FE, 16'h0});
         end
      end
      bus.spi_csn = 1'b1;
      half_period();
      half_period();
      if (rst_at < 0) begin
         e    = {48'h0, expm};
         expv = (nbits <= 16) ? (e >> (16 - nbits)) : (e << (nbits - 16));
         check("miso_read", rd, expv);
      end
      check("rx_data_hold", {48'h0, bus.rx_data}, {48'h0, last_rx});
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", evq.size());
      $fatal(1);
   end

   initial begin
      total        = 0;
      bad          = 0;
      model_full   = 1'b0;
      model_hold   = 16'h0;
      last_rx      = 16'h0;
      rst_n        = 1'b0;
      bus.spi_csn  = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.tx_data  = 16'h0;
      bus.tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_miso",     {63'h0, bus.spi_miso},    64'h0);
      check("rst_miso_t",   {63'h0, bus.spi_miso_t},  64'h1);
      check("rst_tx_ready", {63'h0, bus.tx_ready},    64'h1);
      check("rst_rx_data",  {48'h0, bus.rx_data},     64'h0);
      check("rst_strobes",  {61'h0, bus.rx_valid, bus.tx_underrun, bus.frame_err}, 64'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // normal frame, then underrun frame
      load_tx(16'hA5C3);
      frame(16'h8B0E, 16, -1, 1'b0, 16'h0);
      check("tx_ready_after", {63'h0, bus.tx_ready}, 64'h1);
      frame(16'h3C96, 16, -1, 1'b0, 16'h0);

      // short and long frames
      frame(16'hABC0, 12, -1, 1'b0, 16'h0);
      frame(16'h5555, 20, -1, 1'b0, 16'h0);

      // reset mid-frame, then recovery
      load_tx(16'h1357);
      frame(16'hFFFF, 16, 7, 1'b0, 16'h0);
      check("post_rst_tx_ready", {63'h0, bus.tx_ready}, 64'h1);
      check("post_rst_rx_data",  {48'h0, bus.rx_data},  64'h0);
      load_tx(16'h2468);
      frame(16'h4242, 16, -1, 1'b0, 16'h0);

      // word offered in the csn_fall cycle, then a word offered while full
      frame(16'h9999, 16, -1, 1'b1, 16'h1234);
      load_tx(16'h5678);
      frame(16'h7777, 16, -1, 1'b0, 16'h0);
      frame(16'h1111, 16, -1, 1'b0, 16'h0);

      // SCLK activity with CSN high
      for (int i = 0; i < 40; i++) begin
         bus.spi_sclk = ~bus.spi_sclk;
         repeat (4) @(negedge clk);
         check("desel_miso_t", {63'h0, bus.spi_miso_t}, 64'h1);
         check("desel_miso",   {63'h0, bus.spi_miso},   64'h0);
      end
      bus.spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
      load_tx(16'hC0DE);
      frame(16'h0F0F, 16, -1, 1'b0, 16'h0);

      repeat (10) @(negedge clk);
      check("evq_drained", 64'(evq.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
